// File: rtl/acc_pkg.sv
// acc_pkg
// Shared definitions for the accelerator memory arbiter slice:
//   - arbiter FSM state encoding (RUN / DRAIN)
//   - default accelerator address map constants
//   - clog2 helper used to size tag and counter fields
// No ports (package).

package acc_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } arb_state_e;

  localparam logic [31:0] TAP_BASE  = 32'h3800_0000;
  localparam logic [31:0] DATA_BASE = 32'h3800_0040;
  localparam logic [31:0] OUT_BASE  = 32'h3800_0080;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/acc_tag_fifo.sv
// acc_tag_fifo
// Synchronous in-order FIFO holding the requester tag of every outstanding
// read. Push while full is honoured only when a pop happens in the same
// cycle; pop while empty is ignored.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties FIFO)
//   push, din       write a tag
//   pop, dout       remove the head tag; dout always shows the head
//   full, empty     occupancy flags
//   count           number of stored tags (0..DEPTH)

module acc_tag_fifo
  import acc_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  localparam int PW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop frees the head slot in the same cycle, so a push into a full
  // FIFO is legal when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage has no reset; contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter
// Shares one single-port memory request channel between NREQ requesters
// with round-robin arbitration, routes in-order read returns back to the
// issuing requester via a tag FIFO, and offers a flush/drain handshake.
// Optional build macro: ACC_ARB_STATS_EN adds per-requester saturating
// issue counters (stat_cnt output, stat_clr input).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_val/adr/dat/wrt, req_ack  requester side (NREQ packed slices)
//   rsp_val, rsp_dat              read return, one-hot valid + shared data
//   mem_val/adr/dat/wrt, mem_rdy  memory request channel
//   mem_rval, mem_rdat            memory read return (in order)
//   flush, idle                   drain request / drained indication
//   err_orphan                    sticky: return with nothing outstanding

module acc_mem_arbiter
  import acc_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_val,
  input  logic [NREQ*AW-1:0] req_adr,
  input  logic [NREQ*DW-1:0] req_dat,
  input  logic [NREQ-1:0]    req_wrt,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    rsp_val,
  output logic [DW-1:0]      rsp_dat,
  output logic               mem_val,
  output logic [AW-1:0]      mem_adr,
  output logic [DW-1:0]      mem_dat,
  output logic               mem_wrt,
  input  logic               mem_rdy,
  input  logic               mem_rval,
  input  logic [DW-1:0]      mem_rdat,
  input  logic               flush,
  output logic               idle,
  output logic               err_orphan
`ifdef ACC_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [NREQ*32-1:0] stat_cnt
`endif
);

  localparam int TW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam int CW = clog2(DEPTH) + 1;

  arb_state_e     state;
  arb_state_e     state_nxt;
  logic [TW-1:0]  rr_ptr;
  logic [TW-1:0]  sel;
  logic           found;
  logic [NREQ-1:0] elig;
  logic           issue;
  logic           push;
  logic           pop;
  logic           room;
  logic           err_q;
  logic [TW-1:0]  tag_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  logic [AW-1:0]  adr_arr [NREQ];
  logic [DW-1:0]  dat_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign adr_arr[i] = req_adr[i*AW +: AW];
    assign dat_arr[i] = req_dat[i*DW +: DW];
  end

  acc_tag_fifo #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sel),
    .pop   (pop),
    .dout  (tag_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A read needs a free tag slot; a return in the same cycle frees one.
  // Everything is held off while rst is high so outputs read as zero.
  assign room = !fifo_full || mem_rval;
  assign pop  = mem_rval && !fifo_empty && !rst;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_val[i] && (state == RUN) && !rst && (req_wrt[i] || room);
    end
  end

  // Round-robin scan starting at rr_ptr, wrapping at NREQ.
  always_comb begin : select
    int            idx;
    logic [TW-1:0] cand;
    idx   = 0;
    cand  = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = TW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Request channel is driven straight from the chosen requester.
  always_comb begin
    mem_val = found;
    mem_adr = '0;
    mem_dat = '0;
    mem_wrt = 1'b0;
    req_ack = '0;
    if (found) begin
      mem_adr = adr_arr[sel];
      mem_dat = dat_arr[sel];
      mem_wrt = req_wrt[sel];
    end
    if (issue) req_ack[sel] = 1'b1;
  end

  assign issue = mem_val && mem_rdy;
  assign push  = issue && !mem_wrt;

  // Read returns go to the requester whose tag sits at the FIFO head.
  always_comb begin
    rsp_val = '0;
    rsp_dat = '0;
    if (pop) begin
      rsp_val[tag_head] = 1'b1;
      rsp_dat           = mem_rdat;
    end
  end

  // Priority pointer moves past the requester that just issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (sel == TW'(NREQ - 1)) ? '0 : sel + TW'(1);
    end
  end

  // Orphan returns latch an error until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (mem_rval && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_orphan = err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // RUN/DRAIN control; flush only blocks issue once it has been registered.
  always_comb begin
    state_nxt = state;
    idle      = 1'b0;
    case (state)
      RUN: begin
        if (flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        idle = (fifo_count == '0) && !rst;
        if (!flush) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

`ifdef ACC_ARB_STATS_EN
  logic [31:0] stat_q [NREQ];

  // Saturating issue counters; clear wins over increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || stat_clr) begin
        stat_q[i] <= '0;
      end else if (req_ack[i] && (stat_q[i] != 32'hFFFF_FFFF)) begin
        stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    assign stat_cnt[i*32 +: 32] = stat_q[i];
  end
`endif

endmodule
